// File: rtl/imu_angle_prep.sv
// Raw IMU sample -> five 24-bit angle estimates (mdeg) for the complementary filter.
// One shared 16x16 multiplier is time-sliced across the five channels.
module imu_angle_prep #(
  parameter int GYRO_K     = 1000,
  parameter int GYRO_SHIFT = 14,
  parameter int ACC_K      = 3581,
  parameter int ACC_SHIFT  = 10,
  parameter int YAW_WRAP   = 180000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sample_valid,
  output logic               sample_ready,
  input  logic signed [15:0] gyro_x,
  input  logic signed [15:0] gyro_y,
  input  logic signed [15:0] gyro_z,
  input  logic signed [15:0] acc_x,
  input  logic signed [15:0] acc_y,
  input  logic signed [23:0] pitch_fb,
  input  logic signed [23:0] roll_fb,
  input  logic               zero_yaw,
  output logic signed [23:0] cur_pitch_gyro,
  output logic signed [23:0] cur_roll_gyro,
  output logic signed [23:0] cur_yaw_gyro,
  output logic signed [23:0] cur_pitch_acc,
  output logic signed [23:0] cur_roll_acc,
  output logic               cmp_filter_en
);

  localparam logic signed [15:0] GK  = 16'(GYRO_K);
  localparam logic signed [15:0] ACK = 16'(ACC_K);
  localparam logic signed [25:0] YW  = 26'(YAW_WRAP);
  localparam logic signed [25:0] YW2 = 26'(2 * YAW_WRAP);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_OUT} state_t;

  state_t state_q, state_d;
  logic [2:0] step_q, step_d;

  logic signed [15:0] gx_q, gy_q, gz_q, ax_q, ay_q;
  logic signed [23:0] pfb_q, rfb_q;
  logic signed [23:0] pg_q, rg_q, pa_q, ra_q, yaw_acc_q;
  logic signed [23:0] cur_pg_q, cur_rg_q, cur_yaw_q, cur_pa_q, cur_ra_q;
  logic               en_q, zero_pend_q;

  logic signed [15:0] mul_a, mul_k;
  logic signed [23:0] fb_sel;
  logic               gyro_ch;
  logic signed [31:0] product, term;
  logic signed [25:0] gyro_sum, yaw_base, yaw_sum, yaw_wrapped;

  function automatic logic signed [23:0] sat24(input logic signed [31:0] v);
    if (v > 32'sd8388607)       return 24'sh7fffff;
    else if (v < -32'sd8388608) return 24'sh800000;
    else                        return v[23:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    case (state_q)
      S_IDLE: if (sample_valid) begin
        state_d = S_CALC;
        step_d  = '0;
      end
      S_CALC: begin
        step_d = step_q + 3'd1;
        if (step_q == 3'd4) state_d = S_OUT;
      end
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Channel order on the multiplier: pitch gyro, roll gyro, yaw, pitch acc, roll acc.
  always_comb begin
    mul_a   = gy_q;
    mul_k   = GK;
    fb_sel  = pfb_q;
    gyro_ch = 1'b1;
    case (step_q)
      3'd1: begin mul_a = gx_q; fb_sel = rfb_q; end
      3'd2: mul_a = gz_q;
      3'd3: begin mul_a = ax_q; mul_k = ACK; gyro_ch = 1'b0; end
      3'd4: begin mul_a = ay_q; mul_k = ACK; gyro_ch = 1'b0; end
      default: ;
    endcase
    product  = 32'(mul_a) * 32'(mul_k);
    term     = gyro_ch ? (product >>> GYRO_SHIFT) : (product >>> ACC_SHIFT);
    gyro_sum = 26'(fb_sel) + $signed(term[25:0]);
    // A zero request arriving on the yaw edge itself still applies to this sample.
    yaw_base = (zero_pend_q || zero_yaw) ? 26'sd0 : 26'(yaw_acc_q);
    yaw_sum  = yaw_base + $signed(term[25:0]);
    yaw_wrapped = yaw_sum;
    if (yaw_sum >= YW)       yaw_wrapped = yaw_sum - YW2;
    else if (yaw_sum < -YW)  yaw_wrapped = yaw_sum + YW2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gx_q <= '0; gy_q <= '0; gz_q <= '0; ax_q <= '0; ay_q <= '0;
      pfb_q <= '0; rfb_q <= '0;
      pg_q <= '0; rg_q <= '0; pa_q <= '0; ra_q <= '0; yaw_acc_q <= '0;
      cur_pg_q <= '0; cur_rg_q <= '0; cur_yaw_q <= '0; cur_pa_q <= '0; cur_ra_q <= '0;
      en_q <= 1'b0;
      zero_pend_q <= 1'b0;
    end else begin
      en_q <= 1'b0;
      if (state_q == S_CALC && step_q == 3'd2) zero_pend_q <= 1'b0;
      else if (zero_yaw)                       zero_pend_q <= 1'b1;
      case (state_q)
        S_IDLE: if (sample_valid) begin
          gx_q <= gyro_x; gy_q <= gyro_y; gz_q <= gyro_z;
          ax_q <= acc_x;  ay_q <= acc_y;
          pfb_q <= pitch_fb; rfb_q <= roll_fb;
        end
        S_CALC: case (step_q)
          3'd0: pg_q      <= sat24(32'(gyro_sum));
          3'd1: rg_q      <= sat24(32'(gyro_sum));
          3'd2: yaw_acc_q <= sat24(32'(yaw_wrapped));
          3'd3: pa_q      <= sat24(term);
          3'd4: ra_q      <= sat24(term);
          default: ;
        endcase
        S_OUT: begin
          cur_pg_q  <= pg_q;
          cur_rg_q  <= rg_q;
          cur_yaw_q <= yaw_acc_q;
          cur_pa_q  <= pa_q;
          cur_ra_q  <= ra_q;
          en_q      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign sample_ready   = (state_q == S_IDLE);
  assign cur_pitch_gyro = cur_pg_q;
  assign cur_roll_gyro  = cur_rg_q;
  assign cur_yaw_gyro   = cur_yaw_q;
  assign cur_pitch_acc  = cur_pa_q;
  assign cur_roll_acc   = cur_ra_q;
  assign cmp_filter_en  = en_q;

endmodule

// File: tb/tb_imu_angle_prep.sv
// Directed bench for imu_angle_prep: hand-computed angles, latency, handshake and reset.
module tb_imu_angle_prep;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sample_valid = 1'b0;
  logic sample_ready;
  logic signed [15:0] gyro_x = '0, gyro_y = '0, gyro_z = '0, acc_x = '0, acc_y = '0;
  logic signed [23:0] pitch_fb = '0, roll_fb = '0;
  logic zero_yaw = 1'b0;
  logic signed [23:0] cur_pitch_gyro, cur_roll_gyro, cur_yaw_gyro, cur_pitch_acc, cur_roll_acc;
  logic cmp_filter_en;

  int checks = 0;
  int errors = 0;

  imu_angle_prep dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .gyro_x(gyro_x), .gyro_y(gyro_y), .gyro_z(gyro_z), .acc_x(acc_x), .acc_y(acc_y),
    .pitch_fb(pitch_fb), .roll_fb(roll_fb), .zero_yaw(zero_yaw),
    .cur_pitch_gyro(cur_pitch_gyro), .cur_roll_gyro(cur_roll_gyro),
    .cur_yaw_gyro(cur_yaw_gyro), .cur_pitch_acc(cur_pitch_acc),
    .cur_roll_acc(cur_roll_acc), .cmp_filter_en(cmp_filter_en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string tag, input int pg, input int rg, input int yw,
                          input int pa, input int ra);
    chk({tag, " pitch_gyro"}, cur_pitch_gyro, pg);
    chk({tag, " roll_gyro"},  cur_roll_gyro,  rg);
    chk({tag, " yaw_gyro"},   cur_yaw_gyro,   yw);
    chk({tag, " pitch_acc"},  cur_pitch_acc,  pa);
    chk({tag, " roll_acc"},   cur_roll_acc,   ra);
  endtask

  // Accept one sample, scramble the inputs afterwards, and walk to the strobe edge.
  task automatic send(input logic signed [15:0] gx, input logic signed [15:0] gy,
                      input logic signed [15:0] gz, input logic signed [15:0] ax,
                      input logic signed [15:0] ay, input logic signed [23:0] pfb,
                      input logic signed [23:0] rfb, input bit zy3);
    int n = 0;
    while (!sample_ready && n < 20) begin tick(); n++; end
    chk("ready before accept", sample_ready, 1);
    gyro_x = gx; gyro_y = gy; gyro_z = gz; acc_x = ax; acc_y = ay;
    pitch_fb = pfb; roll_fb = rfb; sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    gyro_x = 16'sh1234; gyro_y = 16'sh4321; gyro_z = 16'sh2222;
    acc_x = 16'sh3333; acc_y = 16'sh4444; pitch_fb = 24'sh123456; roll_fb = 24'sh234567;
    for (int e = 1; e <= 5; e++) begin
      if (e == 3 && zy3) zero_yaw = 1'b1;
      tick();
      zero_yaw = 1'b0;
      if (cmp_filter_en !== 1'b0 || sample_ready !== 1'b0)
        chk($sformatf("en/ready low at edge %0d", e), {cmp_filter_en, sample_ready}, 0);
    end
    tick();
    chk("en high at edge 6", cmp_filter_en, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int en_cnt;
    logic [19:0] acc_mask;

    // Reset state
    tick(); tick();
    chk_outs("reset", 0, 0, 0, 0, 0);
    chk("reset en", cmp_filter_en, 0);
    rst = 1'b0;
    chk("reset ready", sample_ready, 1);

    // 1: basic pitch gyro and accel terms, one-cycle strobe
    send(16'sd0, 16'sd16384, 16'sd0, 16'sd1024, 16'sd0, 24'sd5000, 24'sd0, 1'b0);
    chk_outs("t1", 6000, 0, 0, 3581, 0);
    chk("t1 ready with strobe", sample_ready, 1);
    tick();
    chk("t1 en drops", cmp_filter_en, 0);

    // 2: yaw accumulation and zero requests
    do_reset();
    send(16'sd0, 16'sd0, -16'sd16384, 16'sd0, 16'sd0, 24'sd0, 24'sd0, 1'b0);
    chk("t2 yaw first", cur_yaw_gyro, -1000);
    send(16'sd0, 16'sd0, -16'sd16384, 16'sd0, 16'sd0, 24'sd0, 24'sd0, 1'b0);
    chk("t2 yaw second", cur_yaw_gyro, -2000);
    zero_yaw = 1'b1; tick(); zero_yaw = 1'b0;
    chk("t2 yaw unchanged by zero request", cur_yaw_gyro, -2000);
    send(16'sd0, 16'sd0, -16'sd16384, 16'sd0, 16'sd0, 24'sd0, 24'sd0, 1'b0);
    chk("t2 yaw after pending zero", cur_yaw_gyro, -1000);
    send(16'sd0, 16'sd0, -16'sd16384, 16'sd0, 16'sd0, 24'sd0, 24'sd0, 1'b1);
    chk("t2 yaw zero on yaw edge", cur_yaw_gyro, -1000);

    // 3: saturation and rounding toward -inf
    send(16'sd0, 16'sd32767, 16'sd0, 16'sd0, 16'sh8000, 24'sd8388000, 24'sd0, 1'b0);
    chk_outs("t3a", 8388607, 0, -1000, 0, -114592);
    send(16'sd16384, 16'sh8000, 16'sd0, -16'sd1, 16'sd32767, 24'sh800000, -24'sd8388000, 1'b0);
    chk_outs("t3b", -8388608, -8387000, -1000, -4, 114588);

    // 4: yaw wrap at +180000
    do_reset();
    for (int i = 0; i < 90; i++)
      send(16'sd0, 16'sd0, 16'sd32767, 16'sd0, 16'sd0, 24'sd0, 24'sd0, 1'b0);
    chk("t4 yaw after 90", cur_yaw_gyro, 179910);
    send(16'sd0, 16'sd0, 16'sd32767, 16'sd0, 16'sd0, 24'sd0, 24'sd0, 1'b0);
    chk("t4 yaw after 91 wrapped", cur_yaw_gyro, -178091);

    // 5: valid held for 20 cycles
    tick();
    gyro_x = '0; gyro_y = '0; gyro_z = '0; acc_x = '0; acc_y = '0;
    pitch_fb = '0; roll_fb = '0;
    sample_valid = 1'b1;
    acc_mask = '0;
    en_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      acc_mask[i] = sample_ready;
      tick();
      if (cmp_filter_en) en_cnt++;
    end
    sample_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (cmp_filter_en) en_cnt++;
    end
    chk("t5 accept edges", 32'(acc_mask), 32'h0000_4081);
    chk("t5 en pulses", en_cnt, 3);

    // 6: reset on the yaw edge discards the sample and the accumulator
    do_reset();
    send(16'sd0, 16'sd16384, -16'sd16384, 16'sd1024, 16'sd0, 24'sd5000, 24'sd0, 1'b0);
    chk_outs("t6 before", 6000, 0, -1000, 3581, 0);
    tick();
    gyro_z = -16'sd16384; sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_outs("t6 after reset", 0, 0, 0, 0, 0);
    chk("t6 en after reset", cmp_filter_en, 0);
    chk("t6 ready after reset", sample_ready, 1);
    en_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (cmp_filter_en) en_cnt++;
    end
    chk("t6 no strobe from aborted sample", en_cnt, 0);
    send(16'sd0, 16'sd0, -16'sd16384, 16'sd0, 16'sd0, 24'sd0, 24'sd0, 1'b0);
    chk("t6 yaw restarted from zero", cur_yaw_gyro, -1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
